// File: rtl/divs_seq.sv
// divs_seq: sequential signed restoring divider, 2W-bit dividend by W-bit
// divisor, one quotient bit per cycle, valid/ready on both sides.
// Ports: clk, rst_n (async low); in_valid/in_ready, dividend, divisor;
// out_valid/out_ready, quotient, remainder, ovf, dbz.
// Option: define DIVS_SEQ_SAT_EN for overflow flag + quotient saturation.
module divs_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf,
  output logic               dbz
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(W2);
  localparam logic [CW-1:0] LAST = CW'(W2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q;
  logic [W2-1:0]    dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic [W2-1:0]    quo_q;
  logic [CW-1:0]    cnt_q;
  logic             sgn_n_q;
  logic             sgn_d_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             ovf_q;
  logic             dbz_q;
  logic             ovalid_q;
  logic             iready_q;

  logic [W2-1:0]    dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   shl;
  logic             qbit;
  logic [WIDTH-1:0] prem_d;
  logic [W2-1:0]    quo_d;
  logic             q_neg;
  logic [WIDTH-1:0] qf;
  logic [WIDTH-1:0] rs;
  logic             ovf_c;

`ifdef DIVS_SEQ_SAT_EN
  localparam logic [W2-1:0] MAG_POS = (W2'(1) << (WIDTH - 1)) - W2'(1);
  localparam logic [W2-1:0] MAG_NEG = W2'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  always_comb begin
    dvd_abs = dividend[W2-1] ? -dividend : dividend;
    dvs_abs = divisor[WIDTH-1] ? -divisor : divisor;
    // restoring step: shift in next dividend bit, keep trial if >= 0
    shl     = {prem_q, dvd_q[W2-1]};
    qbit    = (shl >= {1'b0, dvs_q});
    prem_d  = qbit ? WIDTH'(shl - {1'b0, dvs_q})
                   : shl[WIDTH-1:0];
    quo_d   = {quo_q[W2-2:0], qbit};
    q_neg   = sgn_n_q ^ sgn_d_q;
    rs      = sgn_n_q ? -prem_d : prem_d;
`ifdef DIVS_SEQ_SAT_EN
    ovf_c   = q_neg ? (quo_d > MAG_NEG) : (quo_d > MAG_POS);
    if (ovf_c) qf = q_neg ? Q_MIN : Q_MAX;
    else       qf = WIDTH'(q_neg ? -quo_d : quo_d);
`else
    ovf_c   = 1'b0;
    qf      = WIDTH'(q_neg ? -quo_d : quo_d);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      prem_q   <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sgn_n_q  <= 1'b0;
      sgn_d_q  <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovalid_q <= 1'b0;
      iready_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            iready_q <= 1'b0;
            dvd_q    <= dvd_abs;
            dvs_q    <= dvs_abs;
            sgn_n_q  <= dividend[W2-1];
            sgn_d_q  <= divisor[WIDTH-1];
            prem_q   <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            if (divisor == '0) begin
              state_q <= DONE;
              dbz_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend[WIDTH-1:0];
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          quo_q  <= quo_d;
          dvd_q  <= dvd_q << 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            ovalid_q <= 1'b1;
            quot_q   <= qf;
            rem_q    <= rs;
            ovf_q    <= ovf_c;
          end
        end
        DONE: begin
          // divide-by-zero enters with out_valid low; raise it a cycle later
          if (!ovalid_q) begin
            ovalid_q <= 1'b1;
          end else if (out_ready) begin
            ovalid_q <= 1'b0;
            iready_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = iready_q;
  assign out_valid = ovalid_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_divs_seq.sv
// tb_divs_seq: directed + random checks of divs_seq against an
// arithmetic reference model (truncating division, dividend-signed remainder).
module tb_divs_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dbz;

  int total = 0;
  int passed = 0;

  divs_seq #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .ovf(ovf),
    .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic o, output logic z,
                                output int lat);
    int sa, sb, qi, ri;
    logic [31:0] qv, rv;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      q = 8'hFF; r = a[7:0]; o = 1'b0; z = 1'b1; lat = 1;
    end else begin
      qi = sa / sb;
      ri = sa % sb;
      qv = qi;
      rv = ri;
      r = rv[7:0];
      z = 1'b0;
      lat = 16;
`ifdef DIVS_SEQ_SAT_EN
      o = (qi > 127) || (qi < -128);
      q = !o ? qv[7:0] : (qi > 0 ? 8'h7F : 8'h80);
`else
      o = 1'b0;
      q = qv[7:0];
`endif
    end
  endfunction

  task automatic run_op(input int a, input int b, input int hold);
    logic [15:0] av;
    logic [7:0]  bv, eq, er;
    logic        eo, ez;
    int          el, n;
    bit          busy_rdy, unstable;
    av = a[15:0];
    bv = b[7:0];
    model(av, bv, eq, er, eo, ez, el);
    chk("in_ready_idle", in_ready, 1);
    dividend = av;
    divisor  = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // garbage operands with in_valid high while busy must be ignored
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    n = 0;
    busy_rdy = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) busy_rdy = 1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, el);
    chk("in_ready_busy", busy_rdy, 0);
    chk("in_ready_done", in_ready, 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("ovf", ovf, eo);
    chk("dbz", dbz, ez);
    if (hold > 0) begin
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
            quotient !== eq || remainder !== er ||
            ovf !== eo || dbz !== ez) unstable = 1;
      end
      in_valid = 1'b0;
      chk("hold_stable", unstable, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dbz", dbz, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(100, 7, 0);
    run_op(-100, 7, 0);
    run_op(100, -7, 0);
    run_op(-100, -7, 0);
    run_op(1000, 7, 0);
    run_op(-32768, -1, 0);
    run_op(-16384, 128, 0);
    run_op(5, 0, 0);
    run_op(9, 3, 0);
    run_op(100, 7, 5);
    run_op(-7, 0, 3);

    // abort mid-calculation
    dividend = 16'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", dbz, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(100, 7, 0);

    for (int k = 0; k < 40; k++) begin
      int a, b;
      a = int'($signed(16'($urandom)));
      b = int'($signed(8'($urandom)));
      if ($urandom_range(0, 7) == 0) b = 0;
      run_op(a, b, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
